// File: rtl/polaris_dbus_ram.sv
// rtl/polaris_dbus_ram.sv - wait-stated 64-bit data-bus RAM with sized, alignment-checked access
module polaris_dbus_ram #(
   parameter int DEPTH_LOG2  = 7,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        dcyc_i,
   input  logic        dstb_i,
   input  logic        dwe_i,
   input  logic [63:0] dadr_i,
   input  logic [1:0]  dsiz_i,
   input  logic        dsigned_i,
   input  logic [63:0] ddat_i,
   output logic [63:0] ddat_o,
   output logic        dack_o,
   output logic        misalign_o
);

   localparam int         DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [2:0]            off_q, off_d;
   logic [1:0]            siz_q, siz_d;
   logic                  sgn_q, sgn_d;
   logic                  we_q, we_d;
   logic [63:0]           dat_q, dat_d;

   logic [63:0]           mem_q [DEPTH];

   logic                  aligned;
   logic                  mem_we;
   logic [7:0]            size_lanes;
   logic [7:0]            lane_en;
   logic [63:0]           wr_shift;
   logic [63:0]           rd_shift;
   logic [63:0]           rd_data;

   // Address bits above the word index only alias the same storage.
   logic                  unused_adr;
   assign unused_adr = ^dadr_i[63:DEPTH_LOG2+3];

   // State and latched request; reset abandons any transfer in flight.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         off_q   <= 3'd0;
         siz_q   <= 2'd0;
         sgn_q   <= 1'b0;
         we_q    <= 1'b0;
         dat_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         siz_q   <= siz_d;
         sgn_q   <= sgn_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
      end
   end

   // Next state: accept in IDLE, count wait states, abort whenever the cycle drops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      off_d   = off_q;
      siz_d   = siz_q;
      sgn_d   = sgn_q;
      we_d    = we_q;
      dat_d   = dat_q;
      unique case (state_q)
         S_IDLE: begin
            if (dcyc_i && dstb_i) begin
               idx_d = dadr_i[DEPTH_LOG2+2:3];
               off_d = dadr_i[2:0];
               siz_d = dsiz_i;
               sgn_d = dsigned_i;
               we_d  = dwe_i;
               dat_d = ddat_i;
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!dcyc_i) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Alignment, byte-lane selection and right-justified, extended read data.
   always_comb begin
      aligned    = 1'b1;
      size_lanes = 8'h01;
      rd_data    = 64'd0;
      unique case (siz_q)
         2'd0: begin
            aligned    = 1'b1;
            size_lanes = 8'h01;
         end
         2'd1: begin
            aligned    = (off_q[0] == 1'b0);
            size_lanes = 8'h03;
         end
         2'd2: begin
            aligned    = (off_q[1:0] == 2'b00);
            size_lanes = 8'h0F;
         end
         default: begin
            aligned    = (off_q == 3'b000);
            size_lanes = 8'hFF;
         end
      endcase
      lane_en  = size_lanes << off_q;
      wr_shift = dat_q << {off_q, 3'b000};
      rd_shift = mem_q[idx_q] >> {off_q, 3'b000};
      unique case (siz_q)
         2'd0:    rd_data = {{56{sgn_q & rd_shift[7]}},  rd_shift[7:0]};
         2'd1:    rd_data = {{48{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
         2'd2:    rd_data = {{32{sgn_q & rd_shift[31]}}, rd_shift[31:0]};
         default: rd_data = rd_shift;
      endcase
   end

   // Bus outputs: acknowledge only while the cycle is still held, data zero otherwise.
   always_comb begin
      dack_o     = (state_q == S_ACK) && dcyc_i;
      misalign_o = dack_o && !aligned;
      mem_we     = dack_o && aligned && we_q;
      ddat_o     = (dack_o && aligned && !we_q) ? rd_data : 64'd0;
   end

   // Storage is never reset; an aligned write commits on the edge that ends ACK.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 8; i++) begin
            if (lane_en[i]) begin
               mem_q[idx_q][i*8 +: 8] <= wr_shift[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_polaris_dbus_ram.sv
// tb/tb_polaris_dbus_ram.sv - self-checking bench for polaris_dbus_ram against a byte-array model
module tb_polaris_dbus_ram;

   localparam int PER = 10;

   logic        clk;
   logic        rst_n;
   logic [1:0]  dcyc;
   logic        dstb;
   logic        dwe;
   logic        dsgn;
   logic [1:0]  dsiz;
   logic [63:0] dadr;
   logic [63:0] dwdat;
   logic [1:0]  ack;
   logic [1:0]  mis;
   logic [63:0] rdat0;
   logic [63:0] rdat1;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  bm [2][1024];
   time         last_ack_t;
   logic [63:0] last_rd;

   initial clk = 1'b0;
   always #(PER/2) clk = ~clk;

   polaris_dbus_ram #(.DEPTH_LOG2(7), .WAIT_STATES(1)) u_dut_ws1 (
      .clk_i(clk), .reset_ni(rst_n), .dcyc_i(dcyc[0]), .dstb_i(dstb), .dwe_i(dwe),
      .dadr_i(dadr), .dsiz_i(dsiz), .dsigned_i(dsgn), .ddat_i(dwdat),
      .ddat_o(rdat0), .dack_o(ack[0]), .misalign_o(mis[0])
   );

   polaris_dbus_ram #(.DEPTH_LOG2(7), .WAIT_STATES(3)) u_dut_ws3 (
      .clk_i(clk), .reset_ni(rst_n), .dcyc_i(dcyc[1]), .dstb_i(dstb), .dwe_i(dwe),
      .dadr_i(dadr), .dsiz_i(dsiz), .dsigned_i(dsgn), .ddat_i(dwdat),
      .ddat_o(rdat1), .dack_o(ack[1]), .misalign_o(mis[1])
   );

   function automatic int ws_of(input int d);
      return (d != 0) ? 3 : 1;
   endfunction

   function automatic logic [63:0] rdat_of(input int d);
      return (d != 0) ? rdat1 : rdat0;
   endfunction

   function automatic bit is_aligned(input logic [63:0] adr, input logic [1:0] siz);
      longint n = longint'(1) << siz;
      return (adr & 64'(n - 1)) == 64'd0;
   endfunction

   function automatic logic [63:0] model_read(input int d, input logic [63:0] adr,
                                              input logic [1:0] siz, input logic sgn);
      int n = 1 << siz;
      logic [63:0] v = 64'd0;
      if (!is_aligned(adr, siz)) return 64'd0;
      for (int k = 0; k < n; k++)
         v = v | (64'(bm[d][(int'(adr[9:0]) + k) % 1024]) << (8 * k));
      if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v;
   endfunction

   function automatic void model_write(input int d, input logic [63:0] adr,
                                       input logic [1:0] siz, input logic [63:0] dat);
      int n = 1 << siz;
      for (int k = 0; k < n; k++)
         bm[d][(int'(adr[9:0]) + k) % 1024] = dat[8*k +: 8];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int d, input logic we, input logic [63:0] adr,
                          input logic [1:0] siz, input logic sgn, input logic [63:0] dat);
      dwe = we; dadr = adr; dsiz = siz; dsgn = sgn; dwdat = dat;
      dstb = 1'b1;
      dcyc[d] = 1'b1;
   endtask

   // After the sampling edge: strobe drops and the request lines carry garbage.
   task automatic scramble();
      #1;
      dstb  = 1'b0;
      dwe   = 1'($urandom);
      dadr  = {$urandom, $urandom};
      dsiz  = 2'($urandom);
      dsgn  = 1'($urandom);
      dwdat = {$urandom, $urandom};
   endtask

   task automatic wait_ack(input int d, output int lat, output logic [63:0] got,
                           output logic m, output logic idle_bad);
      bit seen = 0;
      lat = 0; got = 'x; m = 'x; idle_bad = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (ack[d]) begin
            seen = 1; lat = c; got = rdat_of(d); m = mis[d];
            last_ack_t = $time;
         end else begin
            if (rdat_of(d) != 64'd0 || mis[d]) idle_bad = 1'b1;
            @(posedge clk);
         end
      end
   endtask

   task automatic xfer_tail(input int d, input logic we, input logic [63:0] adr,
                            input logic [1:0] siz, input logic sgn, input logic [63:0] dat,
                            input string tag);
      int lat; logic [63:0] got; logic m; logic ib; bit al; logic [63:0] exp;
      al  = is_aligned(adr, siz);
      exp = model_read(d, adr, siz, sgn);
      @(posedge clk);
      scramble();
      wait_ack(d, lat, got, m, ib);
      @(posedge clk);
      #1 dcyc[d] = 1'b0;
      last_rd = got;
      chk({tag, " latency"}, 64'(lat), 64'(ws_of(d) + 1));
      chk({tag, " misalign"}, 64'(m), 64'(!al));
      chk({tag, " idle outputs"}, 64'(ib), 64'd0);
      if (!we) chk({tag, " rdata"}, got, exp);
      if (we && al) model_write(d, adr, siz, dat);
   endtask

   task automatic xfer(input int d, input logic we, input logic [63:0] adr,
                       input logic [1:0] siz, input logic sgn, input logic [63:0] dat,
                       input string tag);
      @(negedge clk);
      set_req(d, we, adr, siz, sgn, dat);
      xfer_tail(d, we, adr, siz, sgn, dat, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat; logic [63:0] got; logic m; logic ib; logic seen; time t1;
      logic [63:0] adr; logic [1:0] siz; int d;

      rst_n = 1'b0; dcyc = 2'b00; dstb = 1'b0; dwe = 1'b0; dsgn = 1'b0;
      dsiz = 2'd0; dadr = 64'd0; dwdat = 64'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ack", 64'(ack), 64'd0);
      chk("reset misalign", 64'(mis), 64'd0);
      chk("reset rdata ws1", rdat0, 64'd0);
      chk("reset rdata ws3", rdat1, 64'd0);

      // First request present at the first edge after reset release.
      rst_n = 1'b1;
      set_req(0, 1'b1, 64'h0, 2'd3, 1'b0, 64'hA5A5_0000_1111_2222);
      xfer_tail(0, 1'b1, 64'h0, 2'd3, 1'b0, 64'hA5A5_0000_1111_2222, "first after reset");

      // Fill both memories so every later read has a known model value.
      for (int w = 0; w < 128; w++) begin
         xfer(0, 1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, "fill ws1");
         xfer(1, 1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, "fill ws3");
      end

      xfer(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, "dword write");
      xfer(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, "dword read");
      chk("dword read const", last_rd, 64'h0123_4567_89AB_CDEF);

      xfer(0, 1'b1, 64'h13, 2'd0, 1'b0, 64'h80, "byte write");
      xfer(0, 1'b0, 64'h13, 2'd0, 1'b1, 64'h0, "byte read signed");
      chk("byte signed const", last_rd, 64'hFFFF_FFFF_FFFF_FF80);
      xfer(0, 1'b0, 64'h13, 2'd0, 1'b0, 64'h0, "byte read unsigned");
      chk("byte unsigned const", last_rd, 64'h80);
      xfer(0, 1'b0, 64'h10, 2'd3, 1'b1, 64'h0, "dword after byte");
      chk("dword merged const", last_rd, 64'h0123_4567_80AB_CDEF);

      xfer(0, 1'b0, 64'h11, 2'd1, 1'b0, 64'h0, "misaligned half read");
      chk("misaligned half const", last_rd, 64'h0);
      xfer(0, 1'b1, 64'h12, 2'd2, 1'b0, 64'hFFFF_FFFF, "misaligned word write");
      xfer(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, "after misaligned write");
      chk("unchanged const", last_rd, 64'h0123_4567_80AB_CDEF);

      xfer(0, 1'b1, 64'h400, 2'd3, 1'b0, 64'hFEED_FACE_0BAD_F00D, "wrap write");
      t1 = last_ack_t;
      xfer(0, 1'b0, 64'h0, 2'd3, 1'b0, 64'h0, "wrap read");
      chk("wrap const", last_rd, 64'hFEED_FACE_0BAD_F00D);
      chk("ack spacing ws1", 64'(last_ack_t - t1), 64'(3 * PER));
      xfer(1, 1'b0, 64'h8, 2'd2, 1'b1, 64'h0, "spacing a ws3");
      t1 = last_ack_t;
      xfer(1, 1'b0, 64'h4C, 2'd1, 1'b0, 64'h0, "spacing b ws3");
      chk("ack spacing ws3", 64'(last_ack_t - t1), 64'(5 * PER));

      // Abort: cycle dropped during the second wait cycle of a write.
      xfer(1, 1'b1, 64'h20, 2'd3, 1'b0, 64'h1111_2222_3333_4444, "abort setup");
      @(negedge clk);
      set_req(1, 1'b1, 64'h20, 2'd3, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
      @(posedge clk);
      scramble();
      @(posedge clk);
      #1 dcyc[1] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ack[1]) seen = 1'b1;
      end
      chk("abort no ack", 64'(seen), 64'd0);
      xfer(1, 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, "abort readback");
      chk("abort readback const", last_rd, 64'h1111_2222_3333_4444);

      for (int i = 0; i < 120; i++) begin
         d   = (i % 4 == 3) ? 1 : 0;
         siz = 2'($urandom);
         adr = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) adr = adr & ~64'((1 << siz) - 1);
         xfer(d, 1'($urandom), adr, siz, 1'($urandom), {$urandom, $urandom}, "random");
      end

      // Reset during WAIT of a write, cycle still held.
      @(negedge clk);
      set_req(1, 1'b1, 64'h28, 2'd3, 1'b0, 64'hCAFE_CAFE_CAFE_CAFE);
      @(posedge clk);
      scramble();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("wait reset ack", 64'(ack[1]), 64'd0);
      chk("wait reset rdata", rdat1, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1, 1'b0, 64'h28, 2'd3, 1'b0, 64'h0);
      xfer_tail(1, 1'b0, 64'h28, 2'd3, 1'b0, 64'h0, "write killed in wait");

      // Reset during ACK of a write, cycle still held.
      @(negedge clk);
      set_req(0, 1'b1, 64'h18, 2'd3, 1'b0, 64'h5555_6666_7777_8888);
      @(posedge clk);
      scramble();
      wait_ack(0, lat, got, m, ib);
      chk("ack before reset", 64'(ack[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("ack reset ack", 64'(ack[0]), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      dcyc[0] = 1'b0;
      rst_n = 1'b1;
      xfer(0, 1'b0, 64'h18, 2'd3, 1'b0, 64'h0, "write killed in ack");

      // Reset during ACK of a read forces data to zero immediately.
      @(negedge clk);
      set_req(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
      @(posedge clk);
      scramble();
      wait_ack(0, lat, got, m, ib);
      chk("read before reset", got, model_read(0, 64'h10, 2'd3, 1'b0));
      rst_n = 1'b0;
      #1;
      chk("read reset rdata", rdat0, 64'd0);
      chk("read reset misalign", 64'(mis[0]), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      dcyc[0] = 1'b0;
      rst_n = 1'b1;

      xfer(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, "ws1 intact after resets");
      xfer(1, 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, "ws3 intact after resets");
      chk("ws3 intact const", last_rd, 64'h1111_2222_3333_4444);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/polaris_dbus_ram.md
POLARIS_DBUS_RAM -- requirements
Module: polaris_dbus_ram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 7, giving the number of 64-bit memory words as 2**DEPTH_LOG2.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15, giving the number of extra cycles inserted before acknowledge.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dcyc_i  input  1  bus cycle in progress, driven by the CPU D master.
REQ-006 SHALL have port dstb_i  input  1  transfer strobe.
REQ-007 SHALL have port dwe_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port dadr_i  input  64  byte address.
REQ-009 SHALL have port dsiz_i  input  2  size code: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 SHALL have port dsigned_i  input  1  sign-extend read data when 1.
REQ-011 SHALL have port ddat_i  input  64  write data, right-justified.
REQ-012 SHALL have port ddat_o  output  64  read data, right-justified and extended.
REQ-013 SHALL have port dack_o  output  1  one-cycle transfer acknowledge.
REQ-014 SHALL have port misalign_o  output  1  pulses with dack_o when the access was misaligned.

Function
REQ-015 SHALL implement states IDLE, WAIT, ACK.
REQ-016 In IDLE with dcyc_i & dstb_i = 1, SHALL latch dadr_i, dsiz_i, dsigned_i, dwe_i, and ddat_i, then go to ACK if WAIT_STATES = 0, else to WAIT with the counter loaded to WAIT_STATES-1.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to ACK on the cycle the counter is 0.
REQ-018 Latency from the request-sampling edge to dack_o high SHALL be exactly WAIT_STATES+1 cycles.
REQ-019 In ACK, SHALL drive dack_o = 1 for exactly one cycle, then return to IDLE.
REQ-020 Back-to-back requests: IDLE SHALL accept a new request on the cycle after ACK, with no extra dead cycle.
REQ-021 If dcyc_i = 0 in WAIT or ACK, SHALL abort: return to IDLE next edge, dack_o = 0, no write performed.
REQ-022 Word index SHALL be latched address bits [DEPTH_LOG2+2:3]; higher address bits are ignored, so addresses wrap modulo memory size.
REQ-023 Alignment rule: byte is always aligned; half requires adr[0] = 0; word requires adr[1:0] = 0; dword requires adr[2:0] = 0.
REQ-024 Misaligned access SHALL still be acknowledged; a write SHALL be suppressed, a read SHALL return 0, and misalign_o = 1 during ACK.
REQ-025 An aligned write SHALL update only the byte lanes adr[2:0] .. adr[2:0]+size_bytes-1, taking data from ddat bits starting at bit 0; the commit occurs at the rising edge that ends the ACK cycle.
REQ-026 An aligned read SHALL shift the addressed word right by adr[2:0]*8, mask it to the size, and sign-extend from the top bit of the size when dsigned_i was 1, else zero-extend; dword reads SHALL ignore dsigned_i.
REQ-027 ddat_o SHALL be 0 whenever dack_o = 0.
REQ-028 A read SHALL return data reflecting all writes acknowledged before it.
REQ-029 dstb_i dropping while dcyc_i remains 1 after the request is latched SHALL NOT abort the transfer.

Reset
REQ-030 While reset_ni = 0, SHALL force state = IDLE, counter = 0, dack_o = 0, ddat_o = 0, misalign_o = 0, independent of clk_i.
REQ-031 Memory contents SHALL NOT be altered by reset.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer; a pending write SHALL NOT commit.
REQ-033 After reset_ni rises, the first request SHALL be accepted on the first rising edge at which it is present.

Verification
REQ-034 Scenario: WAIT_STATES = 1; write dword 0x0123456789ABCDEF to 0x10, then read 0x10 -> dack_o 2 cycles after each request; read returns 0x0123456789ABCDEF.
REQ-035 Scenario: write byte 0x80 to 0x13, then read byte signed at 0x13 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; dword at 0x10 -> 0x0123456780ABCDEF.
REQ-036 Scenario: read half at 0x11 -> dack_o = 1, misalign_o = 1, ddat_o = 0; a subsequent misaligned word write to 0x12 leaves the memory unchanged.
REQ-037 Scenario: WAIT_STATES = 3; drop dcyc_i in the 2nd wait cycle of a write -> no dack_o, memory unchanged, next request is serviced normally.
REQ-038 Scenario: assert reset_ni = 0 during WAIT of a write -> outputs 0 immediately, write not committed, earlier memory data intact.
REQ-039 Scenario: DEPTH_LOG2 = 7; write to 0x400 then read 0x0 -> same data (wrap); back-to-back requests are acked every WAIT_STATES+2 cycles.
